// File: rtl/sine_seq_ctrl.sv
// sine_seq_ctrl: sample-tick sequencer for the sine synthesis path.
// Each accepted tick fetches one ROM word at the current phase, shifts it
// MSB-first to the serial DAC, pulses soc, then advances the phase by step.
// Optional feature: define SINE_SEQ_QUARTER_EN for a quarter-wave ROM
// (rom_addr narrows to ADDR_W-2 bits; address mirroring and word negation
// rebuild the full period from the first quadrant).
module sine_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              tick,
  input  logic [ADDR_W-1:0] step,
`ifdef SINE_SEQ_QUARTER_EN
  output logic [ADDR_W-3:0] rom_addr,
`else
  output logic [ADDR_W-1:0] rom_addr,
`endif
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_data,
  output logic              SO,
  output logic              SI_en,
  output logic              soc,
  output logic              busy,
  output logic              overrun
);

`ifdef SINE_SEQ_QUARTER_EN
  localparam int RA_W = ADDR_W - 2;
`else
  localparam int RA_W = ADDR_W;
`endif
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [ADDR_W-1:0] phase_r;
  logic              overrun_r;
  logic [RA_W-1:0]   rom_addr_r;
  logic              rom_rd_r;
  logic              si_en_r;
  logic              soc_r;
  logic              busy_r;
  logic [DATA_W-1:0] shift_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [RA_W-1:0]   addr_map_s;
  logic [DATA_W-1:0] word_map_s;

`ifdef SINE_SEQ_QUARTER_EN
  logic              neg_r;

  // Quarter-wave mapping: mirror the address in odd quadrants, negate the word in the second half-period
  always_comb begin
    addr_map_s = phase_r[ADDR_W-3:0];
    word_map_s = rom_data;
    if (phase_r[ADDR_W-2]) begin
      addr_map_s = ~phase_r[ADDR_W-3:0];
    end else begin
      addr_map_s = phase_r[ADDR_W-3:0];
    end
    if (neg_r) begin
      word_map_s = {DATA_W{1'b1}} - rom_data;
    end else begin
      word_map_s = rom_data;
    end
  end

  // Remember the half-period of the phase seen during FETCH for the capture in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_r <= 1'b0;
    end else if (state_r == S_FETCH) begin
      neg_r <= phase_r[ADDR_W-1];
    end
  end
`else
  // Full-wave ROM: phase is the address and the word passes through untouched
  always_comb begin
    addr_map_s = phase_r;
    word_map_s = rom_data;
  end
`endif

  // Next-state logic of the frame sequencer
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (tick && en) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_FETCH: next_state_s = S_WAIT;
      S_WAIT:  next_state_s = S_SHIFT;
      S_SHIFT: begin
        if (bit_cnt_r == {CNT_W{1'b0}}) begin
          next_state_s = S_LOAD;
        end else begin
          next_state_s = S_SHIFT;
        end
      end
      S_LOAD:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Phase accumulator and sticky overrun; a disabled idle sequencer rewinds both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r   <= {ADDR_W{1'b0}};
      overrun_r <= 1'b0;
    end else if ((state_r == S_IDLE) && !en) begin
      phase_r   <= {ADDR_W{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      if (state_r == S_LOAD) begin
        phase_r <= phase_r + step;
      end
      if (tick && (state_r != S_IDLE)) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // Serial datapath: load the ROM word in WAIT, then shift left once per SHIFT cycle.
  // After DATA_W shifts the register is empty, so SO is naturally 0 outside SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= {DATA_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_WAIT: begin
          shift_r   <= word_map_s;
          bit_cnt_r <= CNT_W'(DATA_W - 1);
        end
        S_SHIFT: begin
          shift_r <= {shift_r[DATA_W-2:0], 1'b0};
          if (bit_cnt_r != {CNT_W{1'b0}}) begin
            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
          end
        end
        default: begin
          shift_r   <= shift_r;
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
    end
  end

  // Registered strobes decoded from the state being entered, plus the ROM address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_r <= {RA_W{1'b0}};
      rom_rd_r   <= 1'b0;
      si_en_r    <= 1'b0;
      soc_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      rom_rd_r <= (next_state_s == S_FETCH);
      si_en_r  <= (next_state_s == S_SHIFT);
      soc_r    <= (next_state_s == S_LOAD);
      busy_r   <= (next_state_s != S_IDLE);
      if ((state_r == S_IDLE) && (next_state_s == S_FETCH)) begin
        rom_addr_r <= addr_map_s;
      end
    end
  end

  assign rom_addr = rom_addr_r;
  assign rom_rd   = rom_rd_r;
  assign SO       = shift_r[DATA_W-1];
  assign SI_en    = si_en_r;
  assign soc      = soc_r;
  assign busy     = busy_r;
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Self-checking bench for sine_seq_ctrl with a frame-position reference model.
module tb_sine_seq_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 12;
  localparam int FRAME  = DATA_W + 3;
`ifdef SINE_SEQ_QUARTER_EN
  localparam int RA_W = ADDR_W - 2;
  localparam bit QUARTER = 1'b1;
  localparam logic [RA_W-1:0]   PIN_ADDR = 6'h2F;
  localparam logic [DATA_W-1:0] PIN_WORD = 12'h800;
`else
  localparam int RA_W = ADDR_W;
  localparam bit QUARTER = 1'b0;
  localparam logic [RA_W-1:0]   PIN_ADDR = 8'h50;
  localparam logic [DATA_W-1:0] PIN_WORD = 12'h7FF;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              tick = 1'b0;
  logic [ADDR_W-1:0] step = '0;
  logic [RA_W-1:0]   rom_addr;
  logic              rom_rd;
  logic [DATA_W-1:0] rom_data = '0;
  logic              SO, SI_en, soc, busy, overrun;

  logic [DATA_W-1:0] mem [0:(1<<RA_W)-1];
  int checks = 0;
  int failures = 0;

  sine_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .step(step),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .SO(SO), .SI_en(SI_en), .soc(soc), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ROM model: word valid the cycle after rom_rd, garbage otherwise
  always @(posedge clk) begin
    if (rom_rd) rom_data <= mem[rom_addr];
    else        rom_data <= DATA_W'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RA_W-1:0] map_addr(input logic [ADDR_W-1:0] ph);
`ifdef SINE_SEQ_QUARTER_EN
    return ph[ADDR_W-2] ? ~ph[ADDR_W-3:0] : ph[ADDR_W-3:0];
`else
    return ph;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] fix_word(input logic [ADDR_W-1:0] ph, input logic [DATA_W-1:0] d);
    if (QUARTER && ph[ADDR_W-1]) return DATA_W'((1 << DATA_W) - 1) - d;
    return d;
  endfunction

  // Reference model: pos = cycles since the accepted tick (0 = idle)
  typedef struct {
    int                pos;
    logic [ADDR_W-1:0] phase;
    logic              ovr;
    logic [DATA_W-1:0] word;
    logic [RA_W-1:0]   addr;
  } model_t;

  function automatic model_t model_zero();
    model_t z;
    z.pos = 0; z.phase = '0; z.ovr = 1'b0; z.word = '0; z.addr = '0;
    return z;
  endfunction

  function automatic model_t model_next(input model_t m, input logic en_i, input logic tick_i,
                                        input logic [ADDR_W-1:0] step_i);
    model_t n;
    n = m;
    if (m.pos == 0) begin
      if (!en_i) begin
        n.phase = '0;
        n.ovr   = 1'b0;
      end else if (tick_i) begin
        n.pos  = 1;
        n.addr = map_addr(m.phase);
        n.word = fix_word(m.phase, mem[map_addr(m.phase)]);
      end
    end else begin
      if (tick_i) n.ovr = 1'b1;
      if (m.pos == FRAME) begin
        n.phase = ADDR_W'((int'(m.phase) + int'(step_i)) % (1 << ADDR_W));
        n.pos   = 0;
      end else begin
        n.pos = m.pos + 1;
      end
    end
    return n;
  endfunction

  model_t m = model_zero();

  // Model advance on each clock, reset asynchronously like the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_zero();
    else        m <= model_next(m, en, tick, step);
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int  p;
    logic sh;
    p  = m.pos;
    sh = (p >= 3) && (p <= DATA_W + 2);
    chk("busy",     32'(busy),     32'(p != 0));
    chk("rom_rd",   32'(rom_rd),   32'(p == 1));
    chk("si_en",    32'(SI_en),    32'(sh));
    chk("so",       32'(SO),       sh ? 32'(m.word[DATA_W-1-(p-3)]) : 32'd0);
    chk("soc",      32'(soc),      32'(p == FRAME));
    chk("rom_addr", 32'(rom_addr), 32'(m.addr));
    chk("overrun",  32'(overrun),  32'(m.ovr));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] pat;
    logic [RA_W-1:0]   addr_tab [5];
    logic [RA_W+5:0]   ov;
    int n_soc;
    pat = 12'hA5C;
`ifdef SINE_SEQ_QUARTER_EN
    addr_tab[0] = 6'h00; addr_tab[1] = 6'h3F; addr_tab[2] = 6'h00; addr_tab[3] = 6'h3F; addr_tab[4] = 6'h00;
`else
    addr_tab[0] = 8'h00; addr_tab[1] = 8'h40; addr_tab[2] = 8'h80; addr_tab[3] = 8'hC0; addr_tab[4] = 8'h00;
`endif
    for (int i = 0; i < (1 << RA_W); i++) mem[i] = pat;

    // Pin the model's mapping rules with hand-computed values
    chk("pin_map",  32'(map_addr(8'h50)), 32'(PIN_ADDR));
    chk("pin_neg",  32'(fix_word(8'hC0, 12'h7FF)), 32'(PIN_WORD));

    // Reset held with tick toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ov = {rom_addr, rom_rd, SO, SI_en, soc, busy, overrun};
      chk("rst_outs", 32'(ov), 32'd0);
      tick = ~tick;
    end
    tick = 1'b0;
    rst_n = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ov = {rom_addr, rom_rd, SO, SI_en, soc, busy, overrun};
      chk("post_rst_outs", 32'(ov), 32'd0);
    end

    // Single frame with word 0xA5C
    step = 8'h01;
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("c1_rom_rd", 32'(rom_rd), 32'd1);
    chk("c1_rom_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < DATA_W; k++) begin
      chk("a5c_si_en", 32'(SI_en), 32'd1);
      chk("a5c_so", 32'(SO), 32'(pat[DATA_W-1-k]));
      chk("a5c_no_soc", 32'(soc), 32'd0);
      @(negedge clk);
    end
    chk("c15_soc", 32'(soc), 32'd1);
    chk("c15_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("c16_soc", 32'(soc), 32'd0);
    chk("c16_busy", 32'(busy), 32'd0);
    en = 1'b0;
    @(negedge clk);

    // step 0x40, ticks exactly every DATA_W+4 cycles
    en = 1'b1;
    step = 8'h40;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      chk("step40_addr", 32'(rom_addr), 32'(addr_tab[i]));
      repeat (FRAME) @(negedge clk);
    end
    chk("step40_no_overrun", 32'(overrun), 32'd0);

    // Tick 5 cycles into a frame, then drop en mid-frame
    step = 8'h10;
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (4) @(negedge clk);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("overrun_set", 32'(overrun), 32'd1);
    en = 1'b0;
    n_soc = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      @(negedge clk);
      if (soc) n_soc++;
    end
    chk("frame_done", 32'(busy), 32'd0);
    chk("soc_count", 32'(n_soc), 32'd1);
    @(negedge clk);
    chk("overrun_clr", 32'(overrun), 32'd0);
    en = 1'b1;
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("phase_rewind", 32'(rom_addr), 32'd0);

    // Asynchronous reset in cycle 7 of a frame
    repeat (6) @(negedge clk);
    chk("c7_si_en", 32'(SI_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_si_en", 32'(SI_en), 32'd0);
    chk("arst_so", 32'(SO), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_soc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (soc) n_soc++;
    end
    chk("arst_no_soc", 32'(n_soc), 32'd0);

    // Randomized traffic against the model
    en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < (1 << RA_W); i++) mem[i] = DATA_W'($urandom);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 19) != 0);
      tick = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) step = ($urandom_range(0, 3) == 0) ? 8'h00 : ADDR_W'($urandom);
    end
    en = 1'b0;
    tick = 1'b0;
    repeat (FRAME + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
